// File: rtl/axi4lite_write_master_p_if.sv
// AXI4-lite write channels (AW, W, B) between a write master and the interconnect.
interface axi4lite_write_master_p_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   aw_addr;
    logic                aw_valid;
    logic [2:0]          aw_prot;
    logic                aw_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_valid;
    logic                w_ready;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                b_ready;

    modport master (
        output aw_addr, aw_valid, aw_prot, w_data, w_strb, w_valid, b_ready,
        input  aw_ready, w_ready, b_resp, b_valid
    );

    modport slave (
        input  aw_addr, aw_valid, aw_prot, w_data, w_strb, w_valid, b_ready,
        output aw_ready, w_ready, b_resp, b_valid
    );
endinterface

// File: rtl/axi4lite_write_master_p.sv
// AXI4-lite write master: one outstanding write per request/done handshake.
// AW and W are issued together, byte strobes come from the access size, and the
// B response (or a synthetic SLVERR on an optional timeout) is returned as done.
module axi4lite_write_master_p #(
    parameter int         ADDR_W  = 64,
    parameter int         DATA_W  = 64,
    parameter int         TIMEOUT = 0,
    parameter logic [2:0] PROT    = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_size,
    output logic              done_valid,
    output logic [1:0]        done_resp,
    output logic              done_timeout,
    axi4lite_write_master_p_if.master axi
);
    localparam int         NB    = DATA_W / 8;
    localparam int         LNB   = $clog2(NB);
    localparam int         LW    = LNB + 1;
    localparam logic [2:0] LNB3  = 3'(LNB);
    // Counter only has to reach TIMEOUT-1; expiry is detected on that value.
    localparam int         CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, DONE} state_t;

    state_t            state_reg;
    logic              aw_done_reg, w_done_reg;
    logic [CNT_W-1:0]  to_cnt_reg;
    logic              req_ready_reg;
    logic              aw_valid_reg, w_valid_reg, b_ready_reg;
    logic              done_valid_reg, done_timeout_reg;
    logic [1:0]        done_resp_reg;
    logic [ADDR_W-1:0] aw_addr_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic [NB-1:0]     w_strb_reg;

    logic [2:0]        sz;
    logic [LW-1:0]     nbytes;
    logic [LW-1:0]     off;
    logic [LNB-1:0]    lane_mask;
    logic [NB-1:0]     strb_next;
    logic              aw_hs, w_hs, aw_done_now, w_done_now, to_expired;

    // Clamp size to the bus width and force natural alignment of the lane offset.
    always_comb begin
        sz        = (req_size > LNB3) ? LNB3 : req_size;
        nbytes    = LW'(1) << sz;
        lane_mask = LNB'(nbytes - LW'(1));
        off       = {1'b0, req_addr[LNB-1:0] & ~lane_mask};
    end

    // A lane is enabled when it falls inside [off, off + nbytes).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_strb
            assign strb_next[gi] = (LW'(gi) >= off) && (LW'(gi) < (off + nbytes));
        end
    endgenerate

    assign aw_hs       = aw_valid_reg & axi.aw_ready;
    assign w_hs        = w_valid_reg & axi.w_ready;
    assign aw_done_now = aw_done_reg | aw_hs;
    assign w_done_now  = w_done_reg | w_hs;
    assign to_expired  = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            aw_done_reg      <= 1'b0;
            w_done_reg       <= 1'b0;
            to_cnt_reg       <= '0;
            req_ready_reg    <= 1'b1;
            aw_valid_reg     <= 1'b0;
            w_valid_reg      <= 1'b0;
            b_ready_reg      <= 1'b0;
            done_valid_reg   <= 1'b0;
            done_timeout_reg <= 1'b0;
            done_resp_reg    <= 2'b00;
            aw_addr_reg      <= '0;
            w_data_reg       <= '0;
            w_strb_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg  <= 1'b1;
                    done_valid_reg <= 1'b0;
                    if (req_valid) begin
                        req_ready_reg <= 1'b0;
                        aw_addr_reg   <= req_addr;
                        w_data_reg    <= req_data;
                        w_strb_reg    <= strb_next;
                        aw_valid_reg  <= 1'b1;
                        w_valid_reg   <= 1'b1;
                        aw_done_reg   <= 1'b0;
                        w_done_reg    <= 1'b0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (aw_hs) begin
                        aw_valid_reg <= 1'b0;
                        aw_done_reg  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_reg <= 1'b0;
                        w_done_reg  <= 1'b1;
                    end
                    if (aw_done_now && w_done_now) begin
                        b_ready_reg <= 1'b1;
                        to_cnt_reg  <= '0;
                        state_reg   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A response arriving on the expiry cycle takes priority.
                    if (axi.b_valid) begin
                        done_resp_reg    <= axi.b_resp;
                        done_timeout_reg <= 1'b0;
                        b_ready_reg      <= 1'b0;
                        done_valid_reg   <= 1'b1;
                        state_reg        <= DONE;
                    end else if (to_expired) begin
                        done_resp_reg    <= 2'b10;
                        done_timeout_reg <= 1'b1;
                        b_ready_reg      <= 1'b0;
                        done_valid_reg   <= 1'b1;
                        state_reg        <= DONE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg      <= IDLE;
                    req_ready_reg  <= 1'b1;
                    aw_valid_reg   <= 1'b0;
                    w_valid_reg    <= 1'b0;
                    b_ready_reg    <= 1'b0;
                    done_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_reg;
    assign done_valid   = done_valid_reg;
    assign done_resp    = done_resp_reg;
    assign done_timeout = done_timeout_reg;
    assign axi.aw_addr  = aw_addr_reg;
    assign axi.aw_valid = aw_valid_reg;
    assign axi.aw_prot  = PROT;
    assign axi.w_data   = w_data_reg;
    assign axi.w_strb   = w_strb_reg;
    assign axi.w_valid  = w_valid_reg;
    assign axi.b_ready  = b_ready_reg;
endmodule

// File: tb/tb_axi4lite_write_master_p.sv
// Scoreboard bench for axi4lite_write_master_p: a 64-bit instance with TIMEOUT=4
// driven by a delay-programmable slave, plus a 32-bit instance for strobe clamping.
module tb_axi4lite_write_master_p;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    initial forever #5 clk = ~clk;

    // Edge index: value after an edge equals the number of edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // 64-bit DUT
    logic        rv = 1'b0;
    logic        rr;
    logic [63:0] ra = '0;
    logic [63:0] rd = '0;
    logic [2:0]  rs = '0;
    logic        dv;
    logic [1:0]  dr;
    logic        dt;
    axi4lite_write_master_p_if #(.ADDR_W(64), .DATA_W(64)) axi64 ();

    axi4lite_write_master_p #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4), .PROT(3'b010)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv), .req_ready(rr), .req_addr(ra), .req_data(rd), .req_size(rs),
        .done_valid(dv), .done_resp(dr), .done_timeout(dt),
        .axi(axi64)
    );

    // 32-bit DUT
    logic        rv32 = 1'b0;
    logic        rr32;
    logic [31:0] ra32 = '0;
    logic [31:0] rd32 = '0;
    logic [2:0]  rs32 = '0;
    logic        dv32;
    logic [1:0]  dr32;
    logic        dt32;
    axi4lite_write_master_p_if #(.ADDR_W(32), .DATA_W(32)) axi32 ();

    axi4lite_write_master_p #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0), .PROT(3'b000)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(rv32), .req_ready(rr32), .req_addr(ra32), .req_data(rd32), .req_size(rs32),
        .done_valid(dv32), .done_resp(dr32), .done_timeout(dt32),
        .axi(axi32)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic        to;
        logic [31:0] cyc;
    } done_t;

    logic [63:0] aw_q[$];
    logic [71:0] w_q[$];
    done_t       done_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Slave model: readies/B delayed by programmable cycle counts (-1 = never answer B).
    int         aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] b_resp_val = 2'b00;
    int         aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    initial begin
        axi64.aw_ready = 1'b0; axi64.w_ready = 1'b0; axi64.b_valid = 1'b0; axi64.b_resp = 2'b00;
        axi32.aw_ready = 1'b0; axi32.w_ready = 1'b0; axi32.b_valid = 1'b0; axi32.b_resp = 2'b00;
        forever begin
            @(negedge clk);
            aw_cnt = axi64.aw_valid ? aw_cnt + 1 : 0;
            w_cnt  = axi64.w_valid  ? w_cnt + 1  : 0;
            b_cnt  = axi64.b_ready  ? b_cnt + 1  : 0;
            axi64.aw_ready = axi64.aw_valid && (aw_cnt > aw_dly);
            axi64.w_ready  = axi64.w_valid && (w_cnt > w_dly);
            axi64.b_valid  = axi64.b_ready && (b_dly >= 0) && (b_cnt > b_dly);
            axi64.b_resp   = b_resp_val;
            axi32.aw_ready = 1'b1;
            axi32.w_ready  = 1'b1;
            axi32.b_valid  = axi32.b_ready;
            axi32.b_resp   = 2'b00;
        end
    end

    // Monitor: compares presented AW/W/done against the scoreboard queues.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (axi64.aw_valid) begin
                chk("aw_prot", 64'(axi64.aw_prot), 64'h2);
                if (aw_q.size() == 0) fail("aw_unexpected");
                else begin
                    chk("aw_addr", axi64.aw_addr, aw_q[0]);
                    if (axi64.aw_ready) void'(aw_q.pop_front());
                end
            end
            if (axi64.w_valid) begin
                if (w_q.size() == 0) fail("w_unexpected");
                else begin
                    logic [71:0] e;
                    e = w_q[0];
                    chk("w_data", axi64.w_data, e[71:8]);
                    chk("w_strb", 64'(axi64.w_strb), 64'(e[7:0]));
                    if (axi64.w_ready) void'(w_q.pop_front());
                end
            end
            if (axi64.b_ready)
                chk("b_ready_before_aw_w_done", 64'(axi64.aw_valid | axi64.w_valid), 64'h0);
            if (dv) begin
                if (done_q.size() == 0) fail("done_unexpected");
                else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_resp", 64'(dr), 64'(d.resp));
                    chk("done_timeout", 64'(dt), 64'(d.to));
                    chk("done_cycle", 64'(cyc), 64'(d.cyc));
                end
            end
        end
    end

    task automatic run_txn(input string tag, input logic [63:0] addr, input logic [63:0] data,
                           input logic [2:0] size, input int awd, input int wd, input int bd,
                           input logic [1:0] resp, input logic [7:0] strb,
                           input logic [1:0] eresp, input logic eto, input bit hold);
        int c0, mx, lat;
        bit got;
        @(negedge clk); #3;
        aw_dly = awd; w_dly = wd; b_dly = bd; b_resp_val = resp;
        chk({tag, "_req_ready_idle"}, 64'(rr), 64'h1);
        aw_q.push_back(addr);
        w_q.push_back({data, strb});
        rv = 1'b1; ra = addr; rd = data; rs = size;
        @(negedge clk); #3;
        c0 = cyc;
        chk({tag, "_req_ready_after_accept"}, 64'(rr), 64'h0);
        if (hold) begin
            ra = ~addr;
            rd = ~data;
        end else begin
            rv = 1'b0;
        end
        mx  = (awd > wd) ? awd : wd;
        lat = (bd < 0 || bd >= 4) ? 4 : bd + 1;
        done_q.push_back('{eresp, eto, 32'(c0 + 1 + mx + lat)});
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #3;
            if (done_q.size() == 0) begin
                got = 1'b1;
                break;
            end
            if (hold) chk({tag, "_req_ready_busy"}, 64'(rr), 64'h0);
        end
        rv = 1'b0;
        if (!got) begin
            fail({tag, "_done_never_seen"});
            done_q.delete();
        end
        chk({tag, "_aw_q_drained"}, 64'(aw_q.size()), 64'h0);
        chk({tag, "_w_q_drained"}, 64'(w_q.size()), 64'h0);
        aw_q.delete();
        w_q.delete();
        $display("txn %s addr=%0h size=%0d resp=%0b timeout=%0b", tag, addr, size, dr, dt);
    endtask

    task automatic run32(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] strb);
        bit got;
        @(negedge clk); #3;
        chk({tag, "_req_ready_idle"}, 64'(rr32), 64'h1);
        rv32 = 1'b1; ra32 = addr; rd32 = 32'hA5A5_0000 | addr; rs32 = size;
        @(negedge clk); #3;
        rv32 = 1'b0;
        chk({tag, "_w_valid"}, 64'(axi32.w_valid), 64'h1);
        chk({tag, "_w_strb"}, 64'(axi32.w_strb), 64'(strb));
        chk({tag, "_aw_addr"}, 64'(axi32.aw_addr), 64'(addr));
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (dv32) begin
                got = 1'b1;
                chk({tag, "_done_resp"}, 64'(dr32), 64'h0);
                break;
            end
        end
        if (!got) fail({tag, "_done_never_seen"});
        $display("txn32 %s addr=%0h size=%0d strb=%0h", tag, addr, size, strb);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #3;
        chk("rst_req_ready", 64'(rr), 64'h1);
        chk("rst_aw_valid", 64'(axi64.aw_valid), 64'h0);
        chk("rst_w_valid", 64'(axi64.w_valid), 64'h0);
        chk("rst_b_ready", 64'(axi64.b_ready), 64'h0);
        chk("rst_done_valid", 64'(dv), 64'h0);
        chk("rst_done_timeout", 64'(dt), 64'h0);
        chk("rst_done_resp", 64'(dr), 64'h0);
        chk("rst_aw_addr", axi64.aw_addr, 64'h0);
        chk("rst_w_data", axi64.w_data, 64'h0);
        chk("rst_w_strb", 64'(axi64.w_strb), 64'h0);
        rst = 1'b0;

        // tag, addr, data, size, awd, wd, bd, resp, strb, eresp, eto, hold
        run_txn("min_latency", 64'h8000_0000, 64'h1122_3344_5566_7788, 3'd3, 0, 0, 0, 2'b00, 8'hFF, 2'b00, 1'b0, 1'b0);
        run_txn("aw_delay3", 64'h0000_1000, 64'h0102_0304_0506_0708, 3'd3, 3, 0, 0, 2'b00, 8'hFF, 2'b00, 1'b0, 1'b0);
        run_txn("w_delay2", 64'h0000_2008, 64'hCAFE_F00D_0000_0001, 3'd3, 0, 2, 1, 2'b00, 8'hFF, 2'b00, 1'b0, 1'b0);
        run_txn("byte_a5", 64'h1234_0005, 64'h0000_5500_0000_0000, 3'd0, 0, 0, 0, 2'b00, 8'h20, 2'b00, 1'b0, 1'b0);
        run_txn("half_a3", 64'h1234_0003, 64'h0000_0000_BEEF_0000, 3'd1, 0, 0, 0, 2'b00, 8'h0C, 2'b00, 1'b0, 1'b0);
        run_txn("half_a6", 64'h1234_0006, 64'hABCD_0000_0000_0000, 3'd1, 1, 1, 0, 2'b00, 8'hC0, 2'b00, 1'b0, 1'b0);
        run_txn("word_a4", 64'h1234_0004, 64'h8765_4321_0000_0000, 3'd2, 0, 0, 0, 2'b00, 8'hF0, 2'b00, 1'b0, 1'b0);
        run_txn("size5_clamp", 64'h1234_0003, 64'hFFEE_DDCC_BBAA_9988, 3'd5, 0, 0, 0, 2'b00, 8'hFF, 2'b00, 1'b0, 1'b0);
        run_txn("slverr_hold", 64'h5555_0007, 64'h1111_2222_3333_4444, 3'd2, 1, 0, 1, 2'b10, 8'hF0, 2'b10, 1'b0, 1'b1);
        run_txn("timeout", 64'h6666_0000, 64'h0000_0000_0000_00AA, 3'd0, 0, 0, -1, 2'b00, 8'h01, 2'b10, 1'b1, 1'b0);
        run_txn("resp_on_expiry", 64'h6666_0010, 64'h0000_0000_0000_BB00, 3'd1, 0, 0, 3, 2'b01, 8'h03, 2'b01, 1'b0, 1'b0);
        run_txn("decerr_b2", 64'h6666_0020, 64'h0000_0000_0000_00CC, 3'd3, 0, 0, 2, 2'b11, 8'hFF, 2'b11, 1'b0, 1'b0);

        // Reset while AW is still pending.
        @(negedge clk); #3;
        aw_dly = 10; w_dly = 0; b_dly = 0;
        aw_q.push_back(64'h0000_4000);
        w_q.push_back({64'h0000_0000_DEAD_BEEF, 8'hFF});
        rv = 1'b1; ra = 64'h0000_4000; rd = 64'h0000_0000_DEAD_BEEF; rs = 3'd3;
        @(negedge clk); #3;
        rv = 1'b0;
        @(negedge clk); #3;
        chk("mid_aw_valid_pending", 64'(axi64.aw_valid), 64'h1);
        rst = 1'b1;
        @(negedge clk); #3;
        rst = 1'b0;
        chk("mid_rst_aw_valid", 64'(axi64.aw_valid), 64'h0);
        chk("mid_rst_w_valid", 64'(axi64.w_valid), 64'h0);
        chk("mid_rst_b_ready", 64'(axi64.b_ready), 64'h0);
        chk("mid_rst_req_ready", 64'(rr), 64'h1);
        chk("mid_rst_done_valid", 64'(dv), 64'h0);
        aw_q.delete();
        w_q.delete();
        done_q.delete();
        $display("txn mid_reset aw_valid=%0b req_ready=%0b", axi64.aw_valid, rr);

        run_txn("after_reset", 64'h0000_7000, 64'h7777_7777_7777_7777, 3'd3, 0, 0, 0, 2'b00, 8'hFF, 2'b00, 1'b0, 1'b0);

        run32("w32_word_a6", 32'h0000_0006, 3'd2, 4'hF);
        run32("w32_byte_a3", 32'h0000_0003, 3'd0, 4'h8);
        run32("w32_dword_clamp", 32'h0000_0002, 3'd3, 4'hF);
        run32("w32_half_a2", 32'h0000_0002, 3'd1, 4'hC);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi4lite_write_master_p.md
Name: axi4lite_write_master_p

Overview:
Parametrised AXI4-lite write master. It replaces the fixed 64-bit, level-enabled write FSM with a request/done handshake. It issues AW and W concurrently and generates byte strobes from the access size. It returns BRESP to the requester and aborts via an optional response timeout. It sits between the LSU/store path and the AXI4-lite interconnect.

Parameters:
ADDR_W, 64, address width (bits)
DATA_W, 64, data width (bits); power of 2, 32 or 64
TIMEOUT, 0, max cycles waiting for B after both AW/W done; 0 = disabled
PROT, 3'b000, constant AWPROT value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  write request
req_ready  out  1  master can accept request
req_addr  in  ADDR_W  byte address
req_data  in  DATA_W  write data, already lane-aligned by requester
req_size  in  3  log2(bytes): 0=B, 1=H, 2=W, 3=D
done_valid  out  1  one-cycle completion pulse
done_resp  out  2  captured BRESP (2'b10 on timeout)
done_timeout  out  1  completion caused by timeout
aw_addr  out  ADDR_W  AWADDR
aw_valid  out  1  AWVALID
aw_prot  out  3  AWPROT = PROT
aw_ready  in  1  AWREADY
w_data  out  DATA_W  WDATA
w_strb  out  DATA_W/8  WSTRB
w_valid  out  1  WVALID
w_ready  in  1  WREADY
b_resp  in  2  BRESP
b_valid  in  1  BVALID
b_ready  out  1  BREADY

Behaviour:
- Reset: state IDLE; aw_valid, w_valid, b_ready, done_valid, done_timeout = 0; done_resp, aw_addr, w_data, w_strb = 0; req_ready = 1 after reset.
- All AXI outputs are registered. Address, data and strobe are latched at acceptance and held stable until the matching handshake.
- States: IDLE, ISSUE, WAIT_B, DONE.
- IDLE: req_ready=1. On req_valid: latch address, data and strobe; set aw_valid=1 and w_valid=1; go to ISSUE. Accept cycle = T0; valids are high at T0+1.
- ISSUE: req_ready=0.
  - aw_valid drops the cycle after aw_valid&aw_ready.
  - w_valid drops the cycle after w_valid&w_ready.
  - The AW and W handshakes are independent. They complete in any order or in the same cycle; done flags aw_done and w_done track them.
  - When both are done (including both in the same cycle): b_ready=1, go to WAIT_B.
  - Valids are never withdrawn before their handshake. No timeout applies in ISSUE.
- WAIT_B: b_ready=1; timeout counter runs.
  - On b_valid: capture b_resp; b_ready=0; go to DONE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without b_valid: done_resp=2'b10, done_timeout=1, b_ready=0, go to DONE.
  - b_valid in the same cycle as expiry: the response wins and done_timeout=0.
- DONE: done_valid=1 for exactly one cycle, then IDLE. req_ready returns to 1 the next cycle. Requests are not pipelined; at most one is outstanding.
- Strobe generation:
  - NB = DATA_W/8; sz = min(req_size, log2(NB)).
  - off = req_addr[log2(NB)-1:0] with the low sz bits cleared (forced natural alignment).
  - w_strb = ((1<<(1<<sz))-1) << off. Example: DATA_W=64, size 1, addr 0x...6 -> 8'b1100_0000.
- aw_addr = req_addr unmodified. w_data = req_data unmodified.
- Minimum latency with aw_ready=w_ready=1 and b_valid answered immediately: accept T0, AW/W handshake T1, B handshake T2, done_valid T3.
- Reset mid-transaction: returns to IDLE immediately and drops all valids. The system-level reset covers the slave.
- Unknown state encodings recover to IDLE.

Test Plan:
- DATA_W=64; size 3, addr 0x8000_0000, data 0x1122334455667788; all ready=1, bvalid answered in WAIT_B -> aw_valid/w_valid high 1 cycle, w_strb=8'hFF, done_valid at T3, done_resp=2'b00.
- aw_ready delayed 3 cycles, w_ready immediate -> w_valid falls at T2, aw_valid held stable with aw_addr constant until handshake, b_ready only after both done.
- Size 0, addr 0x...5 -> w_strb=8'b0010_0000; size 1, addr 0x...3 -> w_strb=8'b0000_1100; size 2, DATA_W=32, addr 0x...6 -> 4'b0000... corrected: off cleared -> 4'b1111.
- b_resp=2'b10 returned -> done_resp=2'b10, done_timeout=0; req_ready low throughout, second req_valid ignored until IDLE.
- TIMEOUT=4, b_valid never asserted -> done_valid exactly 4 cycles after WAIT_B entry, done_resp=2'b10, done_timeout=1; repeat with b_valid on the expiry cycle -> done_timeout=0.
- rst asserted in ISSUE with aw_valid=1 -> next cycle all valids 0, req_ready=1, state IDLE.
